pixel_scaler: RTL and testbench
===============================

PIXEL_SCALER -- requirements
Module: pixel_scaler

Interface
REQ-001 Parameters: PHYS_W=640, active width in physical pixels; PHYS_H=480, active height in physical lines; XW=10, logical_x width; YW=9, logical_y width.
REQ-002 clk_25mhz  input  1  pixel clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 h_count  input  10  physical horizontal counter, 0..799, increments by 1 per clock.
REQ-005 v_count  input  10  physical vertical counter, 0..524, increments when h_count wraps.
REQ-006 display_enable  input  1  active-video qualifier from VGA controller.
REQ-007 mode_sel  input  2  requested scaling mode, per REQ-011.
REQ-008 logical_x  output  XW  logical x coordinate; registered.
REQ-009 logical_y  output  YW  logical y coordinate; registered.
REQ-010 in_display_area, pixel_advance, line_repeat, frame_start  output  1 each  registered flags per REQ-016..REQ-019; active_mode  output  2  currently applied mode.

Function
REQ-011 Modes (logical WxH, scale S, H_OFF, V_OFF): 0 = 320x200, S=2, 0, 40; 1 = 320x240, S=2, 0, 0; 2 = 640x480, S=1, 0, 0; 3 = 160x100, S=4, 0, 40.
REQ-012 Mode latch: active_mode loaded from mode_sel only on a cycle with h_count==0 and v_count==0; mode_sel changes at any other time take no effect until the next frame start.
REQ-013 Output latency: every output at cycle t+1 reflects the h_count/v_count/display_enable sampled at cycle t.
REQ-014 Horizontal: x counter and repeat counter rx (0..S-1) implemented as counters, no divider; at h_count==H_OFF: x=0, rx=0; each following in-window cycle rx increments, and when rx==S-1 it wraps to 0 and x increments; equivalent to x=(h_count-H_OFF)/S.
REQ-015 Vertical: updated on cycles with h_count==0 only; v_count==V_OFF sets y=0, ry=0; other in-window lines increment ry, and wrap at S-1 increments y; equivalent to y=(v_count-V_OFF)/S.
REQ-016 in_display_area = synced AND display_enable AND H_OFF<=h_count<H_OFF+W*S AND V_OFF<=v_count<V_OFF+H*S.
REQ-017 pixel_advance = in_display_area AND rx==0 (first physical pixel of each logical pixel).
REQ-018 line_repeat = in_display_area AND ry!=0 (physical line repeats previous logical line; line-buffer reuse hint).
REQ-019 frame_start: one-cycle pulse, registered, for the sample with h_count==0 and v_count==0; independent of display_enable and synced.
REQ-020 When in_display_area=0, logical_x and logical_y SHALL output 0.
REQ-021 display_enable low inside the geometric window forces the flags to 0 but does not stall the counters.
REQ-022 Last pixel: mode 0 at h_count=639, v_count=439 gives logical_x=319, logical_y=199; no counter overflows past W-1 or H-1.
REQ-023 Arithmetic: window bounds computed in 11-bit unsigned from the table constants; no signed or truncated comparisons.

Reset
REQ-024 reset low asynchronously clears every output to 0 and sets active_mode=0, x, y, rx, ry=0, and synced=0.
REQ-025 synced is set at the first v_count==V_OFF line start after reset release; until then in_display_area, pixel_advance, and line_repeat stay 0, including after a mid-frame reset.

Verification
REQ-026 Mode 0, full frame -> first active output at h=0, v=40: x=0, y=0, pixel_advance=1; at h=1: x=0, pixel_advance=0; at h=639, v=439: x=319, y=199; at v=440: in_display_area=0.
REQ-027 Mode 3, v=41..43 -> y=0, line_repeat=1; at v=44: y=1, line_repeat=0; x increments every 4 clocks.
REQ-028 mode_sel changed 0->2 at v=100 -> active_mode stays 0 for the rest of the frame; switches to 2 on the cycle after h=0, v=0; next frame at h=639: x=639, no line_repeat.
REQ-029 reset asserted at h=300, v=200 -> all outputs 0 immediately; after release, in_display_area stays 0 until v==V_OFF of the next frame, then outputs match the golden model.
REQ-030 display_enable deasserted for h=100..109 in mode 1 -> flags 0 and logical_x=0 for those outputs; at h=110: x=55, matching an unstalled count.
REQ-031 Random mode_sel and reset stress over 20 frames -> outputs cycle-exact against a (count-OFF)/S reference model with 1-cycle latency.

Source files
------------

// File: rtl/pixel_scaler.sv
// Maps physical VGA counters onto a logical, integer-scaled framebuffer grid.
// Horizontal and vertical positions come from counters, not dividers, and
// every output is registered one clock after its h/v sample.
module pixel_scaler #(
  parameter int PHYS_W = 640,
  parameter int PHYS_H = 480,
  parameter int XW     = 10,
  parameter int YW     = 9
)(
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  input  logic          display_enable,
  input  logic [1:0]    mode_sel,
  output logic [XW-1:0] logical_x,
  output logic [YW-1:0] logical_y,
  output logic          in_display_area,
  output logic          pixel_advance,
  output logic          line_repeat,
  output logic          frame_start,
  output logic [1:0]    active_mode
);

  logic [XW-1:0] x_q, cx;
  logic [YW-1:0] y_q, cy;
  logic [1:0]    rx_q, crx, ry_q, cry;
  logic          synced, c_synced, c_in;
  logic          frame, line_start, h_win, v_win;
  logic [1:0]    eff_mode, sh, s_m1;
  logic [10:0]   lw, lh, h_off, v_off, h_end, v_end, h_ext, v_ext;

  // The frame-start sample already uses the newly requested mode.
  assign frame      = (h_count == 10'd0) && (v_count == 10'd0);
  assign line_start = (h_count == 10'd0);
  assign eff_mode   = frame ? mode_sel : active_mode;
  assign h_ext      = {1'b0, h_count};
  assign v_ext      = {1'b0, v_count};

  // Mode table: logical size, log2 of scale, and window offsets.
  always_comb begin
    lw = 11'd320; lh = 11'd200; sh = 2'd1; h_off = 11'd0; v_off = 11'd40;
    case (eff_mode)
      2'd0: begin lw = 11'd320;    lh = 11'd200;    sh = 2'd1; v_off = 11'd40; end
      2'd1: begin lw = 11'd320;    lh = 11'd240;    sh = 2'd1; v_off = 11'd0;  end
      2'd2: begin lw = 11'(PHYS_W); lh = 11'(PHYS_H); sh = 2'd0; v_off = 11'd0;  end
      default: begin lw = 11'd160; lh = 11'd100;    sh = 2'd2; v_off = 11'd40; end
    endcase
  end

  assign s_m1  = (sh == 2'd0) ? 2'd0 : (sh == 2'd1) ? 2'd1 : 2'd3;
  assign h_end = h_off + (lw << sh);
  assign v_end = v_off + (lh << sh);
  assign h_win = (h_ext >= h_off) && (h_ext < h_end);
  assign v_win = (v_ext >= v_off) && (v_ext < v_end);

  // Horizontal counter: restart at the window edge, step rx, carry into x.
  // Outside the window the counters hold, so x never passes W-1.
  always_comb begin
    cx  = x_q;
    crx = rx_q;
    if (h_ext == h_off) begin
      cx  = '0;
      crx = 2'd0;
    end else if (h_win) begin
      if (rx_q == s_m1) begin
        crx = 2'd0;
        cx  = x_q + XW'(1);
      end else begin
        crx = rx_q + 2'd1;
      end
    end
  end

  // Vertical counter: only advances on the first pixel of each line.
  always_comb begin
    cy  = y_q;
    cry = ry_q;
    if (line_start) begin
      if (v_ext == v_off) begin
        cy  = '0;
        cry = 2'd0;
      end else if (v_win) begin
        if (ry_q == s_m1) begin
          cry = 2'd0;
          cy  = y_q + YW'(1);
        end else begin
          cry = ry_q + 2'd1;
        end
      end
    end
  end

  // Vertical alignment is only trusted once a window-top line start is seen.
  assign c_synced = synced | (line_start && (v_ext == v_off));
  assign c_in     = c_synced & display_enable & h_win & v_win;

  // Register counter state and all outputs; coordinates read 0 off-window.
  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      x_q             <= '0;
      rx_q            <= 2'd0;
      y_q             <= '0;
      ry_q            <= 2'd0;
      synced          <= 1'b0;
      active_mode     <= 2'd0;
      logical_x       <= '0;
      logical_y       <= '0;
      in_display_area <= 1'b0;
      pixel_advance   <= 1'b0;
      line_repeat     <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      x_q             <= cx;
      rx_q            <= crx;
      y_q             <= cy;
      ry_q            <= cry;
      synced          <= c_synced;
      active_mode     <= eff_mode;
      logical_x       <= c_in ? cx : '0;
      logical_y       <= c_in ? cy : '0;
      in_display_area <= c_in;
      pixel_advance   <= c_in && (crx == 2'd0);
      line_repeat     <= c_in && (cry != 2'd0);
      frame_start     <= frame;
    end
  end

endmodule

// File: tb/tb_pixel_scaler.sv
// Directed and randomized checks of pixel_scaler. Inputs change 1ns after a
// rising edge, so outputs read 1ns after the next edge belong to that sample.
module tb_pixel_scaler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] h_count = '0, v_count = '0;
  logic       display_enable = 1'b0;
  logic [1:0] mode_sel = '0;
  logic [9:0] logical_x;
  logic [8:0] logical_y;
  logic       in_display_area, pixel_advance, line_repeat, frame_start;
  logic [1:0] active_mode;
  logic [21:0] obs;

  int n_pass = 0;
  int n_tot  = 0;
  int m_mode = 0;
  bit m_syn  = 0;

  pixel_scaler dut (
    .clk_25mhz(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .display_enable(display_enable), .mode_sel(mode_sel),
    .logical_x(logical_x), .logical_y(logical_y),
    .in_display_area(in_display_area), .pixel_advance(pixel_advance),
    .line_repeat(line_repeat), .frame_start(frame_start),
    .active_mode(active_mode)
  );

  always #20 clk = ~clk;

  assign obs = {in_display_area, pixel_advance, line_repeat, logical_x, logical_y};

  task automatic tick(input int h, input int v, input logic de, input logic [1:0] ms);
    h_count = 10'(h); v_count = 10'(v); display_enable = de; mode_sel = ms;
    @(posedge clk); #1;
  endtask

  task automatic run_lines(input int v0, input int v1, input logic [1:0] ms);
    for (int v = v0; v <= v1; v++) tick(0, v, 1'b1, ms);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(5, 50, 1'b1, 2'd3);
    tick(0, 0, 1'b1, 2'd3);
    n_tot++;
    if ({obs, frame_start, active_mode} !== 25'd0)
      $display("FAIL reset_outputs got %h want 0", {obs, frame_start, active_mode});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_mode0_frame;
    tick(0, 0, 1'b1, 2'd0);
    n_tot++;
    if ({frame_start, active_mode} !== 3'b100)
      $display("FAIL m0_frame_start got %b want 100", {frame_start, active_mode});
    else n_pass++;
    tick(1, 0, 1'b1, 2'd0);
    n_tot++;
    if (frame_start !== 1'b0) $display("FAIL m0_fs_pulse got %b want 0", frame_start);
    else n_pass++;
    run_lines(1, 39, 2'd0);
    tick(0, 40, 1'b1, 2'd0);
    n_tot++;
    if (obs !== {3'b110, 10'd0, 9'd0}) $display("FAIL m0_first got %h want %h", obs, {3'b110, 10'd0, 9'd0});
    else n_pass++;
    tick(1, 40, 1'b1, 2'd0);
    n_tot++;
    if (obs !== {3'b100, 10'd0, 9'd0}) $display("FAIL m0_h1 got %h want %h", obs, {3'b100, 10'd0, 9'd0});
    else n_pass++;
    tick(2, 40, 1'b1, 2'd0);
    n_tot++;
    if (obs !== {3'b110, 10'd1, 9'd0}) $display("FAIL m0_h2 got %h want %h", obs, {3'b110, 10'd1, 9'd0});
    else n_pass++;
    run_lines(41, 438, 2'd0);
    for (int h = 0; h <= 639; h++) tick(h, 439, 1'b1, 2'd0);
    n_tot++;
    if (obs !== {3'b101, 10'd319, 9'd199}) $display("FAIL m0_last got %h want %h", obs, {3'b101, 10'd319, 9'd199});
    else n_pass++;
    tick(640, 439, 1'b1, 2'd0);
    n_tot++;
    if (obs !== 22'd0) $display("FAIL m0_h640 got %h want 0", obs);
    else n_pass++;
    tick(0, 440, 1'b1, 2'd0);
    n_tot++;
    if (obs !== 22'd0) $display("FAIL m0_v440 got %h want 0", obs);
    else n_pass++;
  endtask

  task automatic test_mode3;
    tick(0, 0, 1'b1, 2'd3);
    n_tot++;
    if (active_mode !== 2'd3) $display("FAIL m3_latch got %0d want 3", active_mode);
    else n_pass++;
    run_lines(1, 39, 2'd3);
    for (int h = 0; h <= 3; h++) tick(h, 40, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b100, 10'd0, 9'd0}) $display("FAIL m3_h3 got %h want %h", obs, {3'b100, 10'd0, 9'd0});
    else n_pass++;
    tick(4, 40, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b110, 10'd1, 9'd0}) $display("FAIL m3_h4 got %h want %h", obs, {3'b110, 10'd1, 9'd0});
    else n_pass++;
    for (int h = 5; h <= 8; h++) tick(h, 40, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b110, 10'd2, 9'd0}) $display("FAIL m3_h8 got %h want %h", obs, {3'b110, 10'd2, 9'd0});
    else n_pass++;
    tick(0, 41, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b111, 10'd0, 9'd0}) $display("FAIL m3_v41 got %h want %h", obs, {3'b111, 10'd0, 9'd0});
    else n_pass++;
    tick(0, 42, 1'b1, 2'd3);
    tick(0, 43, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b111, 10'd0, 9'd0}) $display("FAIL m3_v43 got %h want %h", obs, {3'b111, 10'd0, 9'd0});
    else n_pass++;
    tick(0, 44, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b110, 10'd0, 9'd1}) $display("FAIL m3_v44 got %h want %h", obs, {3'b110, 10'd0, 9'd1});
    else n_pass++;
  endtask

  task automatic test_mode_switch;
    tick(0, 0, 1'b1, 2'd0);
    run_lines(1, 99, 2'd0);
    tick(0, 100, 1'b1, 2'd2);
    n_tot++;
    if (active_mode !== 2'd0) $display("FAIL sw_hold_v100 got %0d want 0", active_mode);
    else n_pass++;
    run_lines(101, 524, 2'd2);
    n_tot++;
    if (active_mode !== 2'd0) $display("FAIL sw_hold_v524 got %0d want 0", active_mode);
    else n_pass++;
    tick(0, 0, 1'b1, 2'd2);
    n_tot++;
    if ({active_mode, obs} !== {2'd2, 3'b110, 10'd0, 9'd0})
      $display("FAIL sw_apply got %h want %h", {active_mode, obs}, {2'd2, 3'b110, 10'd0, 9'd0});
    else n_pass++;
    for (int h = 1; h <= 639; h++) tick(h, 0, 1'b1, 2'd2);
    n_tot++;
    if (obs !== {3'b110, 10'd639, 9'd0}) $display("FAIL sw_m2_h639 got %h want %h", obs, {3'b110, 10'd639, 9'd0});
    else n_pass++;
    tick(0, 1, 1'b1, 2'd2);
    n_tot++;
    if (obs !== {3'b110, 10'd0, 9'd1}) $display("FAIL sw_m2_v1 got %h want %h", obs, {3'b110, 10'd0, 9'd1});
    else n_pass++;
  endtask

  task automatic test_midframe_reset;
    logic seen;
    seen = 1'b0;
    tick(0, 0, 1'b1, 2'd3);
    run_lines(1, 199, 2'd3);
    for (int h = 0; h <= 300; h++) tick(h, 200, 1'b1, 2'd3);
    n_tot++;
    if (obs !== {3'b110, 10'd75, 9'd40}) $display("FAIL rst_pre got %h want %h", obs, {3'b110, 10'd75, 9'd40});
    else n_pass++;
    reset = 1'b0;
    #3;
    n_tot++;
    if ({obs, frame_start, active_mode} !== 25'd0)
      $display("FAIL rst_async got %h want 0", {obs, frame_start, active_mode});
    else n_pass++;
    reset = 1'b1;
    for (int h = 301; h <= 639; h++) begin
      tick(h, 200, 1'b1, 2'd3);
      seen |= in_display_area;
    end
    for (int v = 201; v <= 524; v++) begin
      tick(0, v, 1'b1, 2'd3);
      seen |= in_display_area;
    end
    n_tot++;
    if (seen !== 1'b0) $display("FAIL rst_unsynced got %b want 0", seen);
    else n_pass++;
    tick(0, 0, 1'b1, 2'd0);
    run_lines(1, 39, 2'd0);
    n_tot++;
    if (obs !== 22'd0) $display("FAIL rst_v39 got %h want 0", obs);
    else n_pass++;
    tick(0, 40, 1'b1, 2'd0);
    n_tot++;
    if (obs !== {3'b110, 10'd0, 9'd0}) $display("FAIL rst_resync got %h want %h", obs, {3'b110, 10'd0, 9'd0});
    else n_pass++;
  endtask

  task automatic test_display_enable;
    tick(0, 0, 1'b1, 2'd1);
    run_lines(1, 9, 2'd1);
    for (int h = 0; h <= 99; h++) tick(h, 10, 1'b1, 2'd1);
    n_tot++;
    if (obs !== {3'b100, 10'd49, 9'd5}) $display("FAIL de_h99 got %h want %h", obs, {3'b100, 10'd49, 9'd5});
    else n_pass++;
    for (int h = 100; h <= 109; h++) begin
      tick(h, 10, 1'b0, 2'd1);
      n_tot++;
      if (obs !== 22'd0) $display("FAIL de_low h=%0d got %h want 0", h, obs);
      else n_pass++;
    end
    tick(110, 10, 1'b1, 2'd1);
    n_tot++;
    if (obs !== {3'b110, 10'd55, 9'd5}) $display("FAIL de_h110 got %h want %h", obs, {3'b110, 10'd55, 9'd5});
    else n_pass++;
  endtask

  task automatic test_random_stress;
    int s, w, hh, vo, em, pick1, pick2, rst_v, hl, ms;
    logic de, e_in, e_pa, e_lr, e_fs;
    logic [9:0] e_x;
    logic [8:0] e_y;
    reset = 1'b0; #3; reset = 1'b1;
    m_mode = 0; m_syn = 0; ms = 0;
    for (int f = 0; f < 20; f++) begin
      pick1 = $urandom_range(0, 524);
      pick2 = $urandom_range(0, 524);
      rst_v = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 524)) : -1;
      for (int v = 0; v <= 524; v++) begin
        if ($urandom_range(0, 7) == 0) ms = $urandom_range(0, 3);
        hl = (v == pick1 || v == pick2) ? int'($urandom_range(600, 799)) : 0;
        for (int h = 0; h <= hl; h++) begin
          de = ($urandom_range(0, 7) != 0);
          tick(h, v, de, 2'(ms));
          em = (h == 0 && v == 0) ? ms : m_mode;
          s  = (em == 2) ? 1 : (em == 3) ? 4 : 2;
          w  = (em == 3) ? 160 : (em == 2) ? 640 : 320;
          hh = (em == 0) ? 200 : (em == 1) ? 240 : (em == 2) ? 480 : 100;
          vo = (em == 0 || em == 3) ? 40 : 0;
          if (h == 0 && v == vo) m_syn = 1;
          e_in = m_syn && de && (h < w * s) && (v >= vo) && (v < vo + hh * s);
          e_x  = e_in ? 10'(h / s) : 10'd0;
          e_y  = e_in ? 9'((v - vo) / s) : 9'd0;
          e_pa = e_in && (h % s == 0);
          e_lr = e_in && ((v - vo) % s != 0);
          e_fs = (h == 0 && v == 0);
          if (h == 0 && v == 0) m_mode = ms;
          n_tot++;
          if ({obs, frame_start, active_mode} !== {e_in, e_pa, e_lr, e_x, e_y, e_fs, 2'(m_mode)})
            $display("FAIL stress f=%0d h=%0d v=%0d got %h want %h", f, h, v,
                     {obs, frame_start, active_mode}, {e_in, e_pa, e_lr, e_x, e_y, e_fs, 2'(m_mode)});
          else n_pass++;
        end
        if (v == rst_v) begin
          reset = 1'b0;
          #3;
          n_tot++;
          if ({obs, frame_start, active_mode} !== 25'd0)
            $display("FAIL stress_reset f=%0d v=%0d got %h want 0", f, v, {obs, frame_start, active_mode});
          else n_pass++;
          reset = 1'b1;
          m_mode = 0; m_syn = 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_frame();
    test_mode3();
    test_mode_switch();
    test_midframe_reset();
    test_display_enable();
    test_random_stress();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
